// File: rtl/multi_channel_pwm_divider.sv
// Multi-channel PWM / clock divider on a shared timebase.
// Period and per-channel compare values are double-buffered: writes land in
// shadow registers and move to the active set only at a period boundary
// (or continuously while stopped), so outputs never glitch mid-period.
module multi_channel_pwm_divider #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned CHW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                Clk50,
  input  logic                Reset,
  input  logic                Enable,
  input  logic                OneShot,
  input  logic [CHANNELS-1:0] Polarity,
  input  logic                PeriodWr,
  input  logic [WIDTH-1:0]    PeriodIn,
  input  logic                CompareWr,
  input  logic [CHW-1:0]      CompareChan,
  input  logic [WIDTH-1:0]    CompareIn,
  output logic [CHANNELS-1:0] Out,
  output logic                Wrap,
  output logic                Done,
  output logic [WIDTH-1:0]    Count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t              state;
  logic [WIDTH-1:0]    count;
  logic [WIDTH-1:0]    count_inc;
  logic [WIDTH-1:0]    shadow_period;
  logic [WIDTH-1:0]    active_period;
  logic [WIDTH-1:0]    shadow_cmp [CHANNELS];
  logic [WIDTH-1:0]    active_cmp [CHANNELS];
  logic                wrap;
  logic                xfer;
  logic [CHANNELS-1:0] pwm;

  // Shadow->active transfer: at every period boundary, and always while stopped
  assign xfer      = (state != RUN) || wrap;
  assign count_inc = count + WIDTH'(1);

  // Timebase FSM; wrap is precomputed so it is high exactly while count==active_period
  always_ff @(posedge Clk50) begin
    if (Reset) begin
      state <= IDLE;
      count <= '0;
      wrap  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          count <= '0;
          if (Enable) begin
            state <= RUN;
            // active period on the next cycle is the current shadow value
            wrap  <= (shadow_period == '0);
          end else begin
            wrap  <= 1'b0;
          end
        end
        RUN: begin
          if (!Enable) begin
            state <= IDLE;
            count <= '0;
            wrap  <= 1'b0;
          end else if (wrap) begin
            count <= '0;
            if (OneShot) begin
              state <= HOLD;
              wrap  <= 1'b0;
            end else begin
              wrap  <= (shadow_period == '0);
            end
          end else begin
            count <= count_inc;
            wrap  <= (count_inc == active_period);
          end
        end
        HOLD: begin
          count <= '0;
          wrap  <= 1'b0;
          if (!Enable) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          count <= '0;
          wrap  <= 1'b0;
        end
      endcase
    end
  end

  // Period shadow/active registers
  always_ff @(posedge Clk50) begin
    if (Reset) begin
      shadow_period <= '0;
      active_period <= '0;
    end else begin
      if (PeriodWr) begin
        shadow_period <= PeriodIn;
      end
      if (xfer) begin
        active_period <= shadow_period;
      end
    end
  end

  // Per-channel compare shadow/active registers; out-of-range channel writes match nothing
  always_ff @(posedge Clk50) begin
    if (Reset) begin
      for (int i = 0; i < int'(CHANNELS); i++) begin
        shadow_cmp[i] <= '0;
        active_cmp[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(CHANNELS); i++) begin
        if (CompareWr && (CompareChan == CHW'(i))) begin
          shadow_cmp[i] <= CompareIn;
        end
        if (xfer) begin
          active_cmp[i] <= shadow_cmp[i];
        end
      end
    end
  end

  // Registered PWM outputs; idle level is the channel polarity
  always_ff @(posedge Clk50) begin
    if (Reset) begin
      pwm <= Polarity;
    end else begin
      for (int i = 0; i < int'(CHANNELS); i++) begin
        pwm[i] <= (state == RUN) ? ((count < active_cmp[i]) ^ Polarity[i]) : Polarity[i];
      end
    end
  end

  assign Out   = pwm;
  assign Count = count;
  assign Wrap  = wrap;
  assign Done  = wrap & OneShot;

endmodule

// File: tb/tb_multi_channel_pwm_divider.sv
// Directed bench for multi_channel_pwm_divider: a 4-channel 32-bit instance
// for the main scenarios and a 3-channel 8-bit instance for the invalid
// channel-select case. Outputs are sampled on the falling edge.
module tb_multi_channel_pwm_divider;

  logic Clk50 = 1'b0;
  always #5 Clk50 = ~Clk50;

  // main instance (WIDTH=32, CHANNELS=4)
  logic        Reset, Enable, OneShot, PeriodWr, CompareWr;
  logic [3:0]  Polarity;
  logic [31:0] PeriodIn, CompareIn;
  logic [1:0]  CompareChan;
  logic [3:0]  Out;
  logic        Wrap, Done;
  logic [31:0] Count;

  // second instance (WIDTH=8, CHANNELS=3)
  logic        reset_b, enable_b, oneshot_b, pwr_b, cwr_b;
  logic [2:0]  pol_b;
  logic [7:0]  pin_b, cin_b;
  logic [1:0]  cch_b;
  logic [2:0]  out_b;
  logic        wrap_b, done_b;
  logic [7:0]  count_b;

  int total = 0;
  int bad   = 0;

  multi_channel_pwm_divider #(.WIDTH(32), .CHANNELS(4)) dut (
    .Clk50(Clk50), .Reset(Reset), .Enable(Enable), .OneShot(OneShot),
    .Polarity(Polarity), .PeriodWr(PeriodWr), .PeriodIn(PeriodIn),
    .CompareWr(CompareWr), .CompareChan(CompareChan), .CompareIn(CompareIn),
    .Out(Out), .Wrap(Wrap), .Done(Done), .Count(Count)
  );

  multi_channel_pwm_divider #(.WIDTH(8), .CHANNELS(3)) dut_b (
    .Clk50(Clk50), .Reset(reset_b), .Enable(enable_b), .OneShot(oneshot_b),
    .Polarity(pol_b), .PeriodWr(pwr_b), .PeriodIn(pin_b),
    .CompareWr(cwr_b), .CompareChan(cch_b), .CompareIn(cin_b),
    .Out(out_b), .Wrap(wrap_b), .Done(done_b), .Count(count_b)
  );

  task automatic tick();
    @(negedge Clk50);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [3:0] e;
    logic [2:0] eb;
    int c, p;

    Reset = 1'b1; Enable = 1'b0; OneShot = 1'b0; Polarity = 4'b1000;
    PeriodWr = 1'b0; PeriodIn = '0; CompareWr = 1'b0; CompareChan = '0; CompareIn = '0;
    reset_b = 1'b1; enable_b = 1'b0; oneshot_b = 1'b0; pol_b = 3'b000;
    pwr_b = 1'b0; pin_b = '0; cwr_b = 1'b0; cch_b = '0; cin_b = '0;
    tick(); tick();

    // reset state
    chk("rst_count", Count, 32'd0);
    chk("rst_out", {28'd0, Out}, 32'h8);
    chk("rst_wrap", {31'd0, Wrap}, 32'd0);
    chk("rst_done", {31'd0, Done}, 32'd0);

    // load period 9 and compares 3,0,10,5 while idle
    Reset = 1'b0; PeriodWr = 1'b1; PeriodIn = 32'd9;
    tick();
    PeriodWr = 1'b0; CompareWr = 1'b1; CompareChan = 2'd0; CompareIn = 32'd3;
    tick();
    CompareChan = 2'd1; CompareIn = 32'd0;
    tick();
    CompareChan = 2'd2; CompareIn = 32'd10;
    tick();
    CompareChan = 2'd3; CompareIn = 32'd5;
    tick();
    CompareWr = 1'b0;
    tick();
    Enable = 1'b1;
    tick();
    chk("run_first_count", Count, 32'd0);
    chk("run_first_out", {28'd0, Out}, 32'h8);

    // two full periods of free-running PWM
    for (int j = 1; j <= 20; j++) begin
      tick();
      c = j % 10;
      p = (j - 1) % 10;
      e = {~(p < 5), 1'b1, 1'b0, (p < 3)};
      chk("pwm_count", Count, 32'(c));
      chk("pwm_wrap", {31'd0, Wrap}, {31'd0, (c == 9)});
      chk("pwm_out", {28'd0, Out}, {28'd0, e});
      chk("pwm_done", {31'd0, Done}, 32'd0);
    end

    // period change mid-period applies at the next boundary
    tick(); chk("pc_count1", Count, 32'd1);
    tick(); chk("pc_count2", Count, 32'd2);
    PeriodWr = 1'b1; PeriodIn = 32'd4;
    tick(); chk("pc_count3", Count, 32'd3);
    PeriodWr = 1'b0;
    for (int k = 4; k <= 9; k++) begin
      tick();
      chk("pc_old_count", Count, 32'(k));
      chk("pc_old_wrap", {31'd0, Wrap}, {31'd0, (k == 9)});
    end
    for (int k = 0; k <= 4; k++) begin
      tick();
      chk("pc_new_count", Count, 32'(k));
      chk("pc_new_wrap", {31'd0, Wrap}, {31'd0, (k == 4)});
    end
    // write in the wrap cycle: next period still uses 4
    PeriodWr = 1'b1; PeriodIn = 32'd6;
    tick(); chk("pw_count0", Count, 32'd0);
    PeriodWr = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("pw_hold_count", Count, 32'(k));
      chk("pw_hold_wrap", {31'd0, Wrap}, {31'd0, (k == 4)});
    end
    for (int k = 0; k <= 6; k++) begin
      tick();
      chk("pw_late_count", Count, 32'(k));
      chk("pw_late_wrap", {31'd0, Wrap}, {31'd0, (k == 6)});
    end

    // disable: count clears, outputs return to idle level
    Enable = 1'b0;
    tick();
    chk("dis_count", Count, 32'd0);
    chk("dis_wrap", {31'd0, Wrap}, 32'd0);
    tick();
    chk("dis_out", {28'd0, Out}, 32'h8);

    // one-shot, period 5, compare[0]=2
    OneShot = 1'b1; PeriodWr = 1'b1; PeriodIn = 32'd5;
    CompareWr = 1'b1; CompareChan = 2'd0; CompareIn = 32'd2;
    tick();
    PeriodWr = 1'b0; CompareWr = 1'b0;
    tick();
    Enable = 1'b1;
    tick();
    chk("os_count0", Count, 32'd0);
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk("os_count", Count, 32'(k));
      chk("os_wrap", {31'd0, Wrap}, {31'd0, (k == 5)});
      chk("os_done", {31'd0, Done}, {31'd0, (k == 5)});
      chk("os_out0", {31'd0, Out[0]}, {31'd0, ((k - 1) < 2)});
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("hold_count", Count, 32'd0);
      chk("hold_wrap", {31'd0, Wrap}, 32'd0);
      chk("hold_done", {31'd0, Done}, 32'd0);
      if (k >= 1) chk("hold_out", {28'd0, Out}, 32'h8);
    end
    // rerun requires Enable low then high
    Enable = 1'b0;
    tick();
    Enable = 1'b1;
    tick();
    chk("os2_count0", Count, 32'd0);
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk("os2_count", Count, 32'(k));
      chk("os2_done", {31'd0, Done}, {31'd0, (k == 5)});
    end
    tick(); chk("os2_hold_a", Count, 32'd0);
    tick(); chk("os2_hold_b", Count, 32'd0);
    chk("os2_hold_done", {31'd0, Done}, 32'd0);

    // reset mid-period at Count=6
    Enable = 1'b0; OneShot = 1'b0;
    tick();
    PeriodWr = 1'b1; PeriodIn = 32'd9;
    tick();
    PeriodWr = 1'b0;
    tick();
    Enable = 1'b1;
    tick();
    for (int k = 1; k <= 6; k++) tick();
    chk("mid_count6", Count, 32'd6);
    Reset = 1'b1;
    tick();
    chk("mr_count", Count, 32'd0);
    chk("mr_wrap", {31'd0, Wrap}, 32'd0);
    chk("mr_done", {31'd0, Done}, 32'd0);
    chk("mr_out", {28'd0, Out}, 32'h8);
    // Enable still high: runs with period 0 and all compares 0
    Reset = 1'b0;
    tick();
    chk("mr_run_count", Count, 32'd0);
    chk("mr_run_wrap", {31'd0, Wrap}, 32'd1);
    tick();
    chk("mr_run_count2", Count, 32'd0);
    chk("mr_run_wrap2", {31'd0, Wrap}, 32'd1);
    chk("mr_run_out", {28'd0, Out}, 32'h8);
    Enable = 1'b0;
    tick();

    // 3-channel instance: write to channel 3 must be ignored
    reset_b = 1'b0; pwr_b = 1'b1; pin_b = 8'd5;
    tick();
    pwr_b = 1'b0; cwr_b = 1'b1; cch_b = 2'd0; cin_b = 8'd1;
    tick();
    cch_b = 2'd1; cin_b = 8'd3;
    tick();
    cch_b = 2'd2; cin_b = 8'd5;
    tick();
    cch_b = 2'd3; cin_b = 8'd0;
    tick();
    cwr_b = 1'b0;
    tick();
    enable_b = 1'b1;
    tick();
    chk("b_count0", {24'd0, count_b}, 32'd0);
    for (int j = 1; j <= 12; j++) begin
      if (j == 3) begin
        cwr_b = 1'b1; cch_b = 2'd3; cin_b = 8'd0;
      end else begin
        cwr_b = 1'b0;
      end
      tick();
      p = (j - 1) % 6;
      eb = {(p < 5), (p < 3), (p < 1)};
      chk("b_count", {24'd0, count_b}, 32'(j % 6));
      chk("b_out", {29'd0, out_b}, {29'd0, eb});
    end
    enable_b = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // global watchdog so the run always ends
  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
